// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_ODD  = 2'b01,
    PAR_EVEN = 2'b10
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam int         CHAR_W         = 9;
  localparam logic [3:0] DATA_BITS_MIN  = 4'd5;
  localparam logic [3:0] DATA_BITS_MAX  = 4'd9;
  localparam logic [3:0] DATA_BITS_DFLT = 4'd8;

  // Out-of-range data-bit settings fall back to the common 8-bit frame.
  function automatic logic [3:0] eff_data_bits(input logic [3:0] b);
    return (b >= DATA_BITS_MIN && b <= DATA_BITS_MAX) ? b : DATA_BITS_DFLT;
  endfunction

  function automatic logic [CHAR_W-1:0] char_mask(input logic [3:0] nbits);
    return {CHAR_W{1'b1}} >> (DATA_BITS_MAX - nbits);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO; flush overrides both read and write.
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_wr, do_rd;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_wr   = wr_en & ~full & ~flush;
  assign do_rd   = rd_en & ~empty & ~flush;

  // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_buf.sv
// UART transmitter with a transmit FIFO; frame format is latched per frame at pop time.
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  input  logic [8:0]                    s_data,
  output logic                          s_ready,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic [3:0]                    cfg_data_bits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  input  logic                          flush,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  tx_state_e         state_q, state_d;
  logic [DIV_W-1:0]  div_cnt_q, div_q;
  logic [3:0]        bit_cnt_q, nbits_q;
  logic [CHAR_W-1:0] shreg_q, fifo_rd_data, new_char;
  logic [3:0]        new_nbits;
  logic              par_en_q, par_bit_q, stop2_q;
  logic              tx_q, tx_d, busy_q, busy_d, done_q, done_d;
  logic              fifo_full, fifo_empty, wr_en, pop, pop_ok;
  logic              bit_end, data_last, stop_last;

  assign s_ready = rst_n & ~flush & ~fifo_full;
  assign wr_en   = s_valid & s_ready;
  assign pop_ok  = ~fifo_empty & ~flush;

  uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CHAR_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .wr_en   (wr_en),
    .wr_data (s_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign new_nbits = eff_data_bits(cfg_data_bits);
  assign new_char  = fifo_rd_data & char_mask(new_nbits);
  assign bit_end   = (div_cnt_q == div_q);
  assign data_last = (bit_cnt_q == nbits_q - 4'd1);
  assign stop_last = (state_q == ST_STOP) && bit_end && (bit_cnt_q == {3'b000, stop2_q});

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (pop_ok) state_d = ST_START;
      ST_START:  if (bit_end) state_d = ST_DATA;
      ST_DATA:   if (bit_end && data_last) state_d = par_en_q ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_end) state_d = ST_STOP;
      ST_STOP:   if (stop_last) state_d = pop_ok ? ST_START : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Line outputs are registered from the current state, so the wire trails the FSM by one cycle.
  always_comb begin
    pop    = pop_ok && ((state_q == ST_IDLE) || stop_last);
    done_d = stop_last;
    busy_d = (state_q != ST_IDLE);
    tx_d   = 1'b1;
    unique case (state_q)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shreg_q[0];
      ST_PARITY: tx_d = par_bit_q;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      div_q     <= '0;
      nbits_q   <= DATA_BITS_DFLT;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      shreg_q   <= '0;
    end else if (pop) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      div_q     <= cfg_div;
      nbits_q   <= new_nbits;
      par_en_q  <= (cfg_parity == PAR_ODD) || (cfg_parity == PAR_EVEN);
      par_bit_q <= (^new_char) ^ (cfg_parity == PAR_ODD);
      stop2_q   <= cfg_stop2;
      shreg_q   <= new_char;
    end else if (state_q != ST_IDLE) begin
      if (bit_end) begin
        div_cnt_q <= '0;
        bit_cnt_q <= (state_d != state_q) ? 4'd0 : bit_cnt_q + 4'd1;
        if (state_q == ST_DATA) shreg_q <= shreg_q >> 1;
      end else begin
        div_cnt_q <= div_cnt_q + DIV_W'(1);
      end
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed bench for uart_tx_buf: frame shapes, FIFO burst, flush and reset behaviour.
module tb_uart_tx_buf;

  localparam int FIFO_DEPTH = 16;
  localparam int DIV_W      = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             s_valid = 1'b0;
  logic [8:0]       s_data = '0;
  logic             s_ready;
  logic [DIV_W-1:0] cfg_div = '0;
  logic [3:0]       cfg_data_bits = 4'd8;
  logic [1:0]       cfg_parity = 2'b00;
  logic             cfg_stop2 = 1'b0;
  logic             flush = 1'b0;
  logic             tx, busy, tx_done;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;

  int   n_chk = 0;
  int   n_err = 0;
  logic cap_tx   [0:255];
  logic cap_done [0:255];
  bit   ok, wr_ok;

  uart_tx_buf #(.FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .cfg_div       (cfg_div),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .flush         (flush),
    .tx            (tx),
    .busy          (busy),
    .tx_done       (tx_done),
    .fifo_level    (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [8:0] d);
    s_valid = 1'b1;
    s_data  = d;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic capture(input int n, input bit perturb);
    for (int k = 0; k < n; k++) begin
      cap_tx[k]   = tx;
      cap_done[k] = tx_done;
      if (perturb && k == 5) begin
        cfg_div       = '0;
        cfg_parity    = 2'b10;
        cfg_data_bits = 4'd5;
        cfg_stop2     = 1'b1;
      end
      tick();
    end
  endtask

  function automatic logic [63:0] pack(input int base, input int n, input bit sel_done);
    logic [63:0] v = '0;
    for (int k = 0; k < n; k++) v[k] = sel_done ? cap_done[base+k] : cap_tx[base+k];
    return v;
  endfunction

  // Expected line, one entry per clock: bits are written in wire order, MSB first.
  function automatic logic [63:0] expand(input logic [15:0] bits, input int nb, input int per);
    logic [63:0] v = '0;
    for (int k = 0; k < nb*per; k++) v[k] = bits[nb-1-k/per];
    return v;
  endfunction

  task automatic wait_done(input int maxc, output bit got);
    got = 1'b0;
    for (int c = 0; c < maxc && !got; c++) begin
      if (tx_done) got = 1'b1;
      else tick();
    end
  endtask

  task automatic run_frame(input string tag, input logic [8:0] d, input int nb,
                           input logic [15:0] bits, input int per, input bit perturb);
    int n;
    n = nb * per;
    push(d);
    tick();
    check({tag, ":lat_tx"}, 64'(tx), 64'd1);
    check({tag, ":lat_busy"}, 64'(busy), 64'd0);
    tick();
    check({tag, ":busy"}, 64'(busy), 64'd1);
    capture(n, perturb);
    check({tag, ":tx"}, pack(0, n, 1'b0), expand(bits, nb, per));
    check({tag, ":done"}, pack(0, n, 1'b1), 64'd1 << (n-1));
    check({tag, ":end_tx"}, 64'(tx), 64'd1);
    check({tag, ":end_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] e;

    // reset state
    repeat (3) tick();
    check("rst:s_ready", 64'(s_ready), 64'd0);
    check("rst:tx", 64'(tx), 64'd1);
    check("rst:busy", 64'(busy), 64'd0);
    check("rst:tx_done", 64'(tx_done), 64'd0);
    check("rst:level", 64'(fifo_level), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst:ready_after", 64'(s_ready), 64'd1);
    tick();

    // frame shapes
    cfg_div = 3; cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    run_frame("8N1", 9'h0A5, 10, 16'b0101001011, 4, 1'b1);
    cfg_div = 1; cfg_data_bits = 4'd7; cfg_parity = 2'b10; cfg_stop2 = 1'b1;
    run_frame("7E2", 9'h003, 11, 16'b01100000011, 2, 1'b0);
    cfg_div = 0; cfg_data_bits = 4'd9; cfg_parity = 2'b01; cfg_stop2 = 1'b0;
    run_frame("9O1", 9'h1FF, 12, 16'b011111111101, 1, 1'b0);
    cfg_div = 2; cfg_data_bits = 4'd5; cfg_parity = 2'b11; cfg_stop2 = 1'b0;
    run_frame("5N1", 9'h1E3, 7, 16'b0110001, 3, 1'b0);
    cfg_div = 0; cfg_data_bits = 4'd15; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    run_frame("bits15", 9'h13C, 10, 16'b0001111001, 1, 1'b0);

    // burst: a slow frame holds the line while the FIFO fills
    cfg_div = 40; cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    push(9'h055);
    tick();
    tick();
    cfg_div = 0;
    for (int i = 0; i < 16; i++) push(9'(i));
    check("burst:level_full", 64'(fifo_level), 64'd16);
    check("burst:ready_full", 64'(s_ready), 64'd0);
    s_valid = 1'b1;
    s_data  = 9'h010;
    repeat (3) tick();
    check("burst:no_overwrite", 64'(fifo_level), 64'd16);
    wr_ok = 1'b0;
    fork
      begin
        for (int c = 0; c < 1000 && !wr_ok; c++) begin
          @(negedge clk);
          if (s_ready) begin
            @(posedge clk);
            #1;
            s_valid = 1'b0;
            wr_ok = 1'b1;
          end
        end
        s_valid = 1'b0;
      end
      begin
        wait_done(600, ok);
        tick();
        capture(170, 1'b0);
      end
    join
    check("burst:17th_write", 64'(wr_ok), 64'd1);
    check("burst:first_done", 64'(ok), 64'd1);
    for (int f = 0; f < 17; f++) begin
      e = '0;
      for (int j = 0; j < 8; j++) e[1+j] = f[j];
      e[9] = 1'b1;
      check($sformatf("burst:frame%0d", f), pack(f*10, 10, 1'b0), e);
      check($sformatf("burst:done%0d", f), pack(f*10, 10, 1'b1), 64'h200);
    end
    check("burst:end_tx", 64'(tx), 64'd1);
    check("burst:end_busy", 64'(busy), 64'd0);
    check("burst:end_level", 64'(fifo_level), 64'd0);

    // flush coinciding with the pop at the end of frame 3
    cfg_div = 1;
    for (int i = 0; i < 8; i++) push(9'(17 + i));
    check("flush:wr_pop_level", 64'(fifo_level), 64'd7);
    wait_done(100, ok);
    check("flush:frame1", 64'(ok), 64'd1);
    tick();
    wait_done(100, ok);
    check("flush:frame2", 64'(ok), 64'd1);
    repeat (19) tick();
    check("flush:queued", 64'(fifo_level), 64'd5);
    flush = 1'b1;
    #1;
    check("flush:ready_low", 64'(s_ready), 64'd0);
    tick();
    flush = 1'b0;
    check("flush:level0", 64'(fifo_level), 64'd0);
    check("flush:frame3_done", 64'(tx_done), 64'd1);
    check("flush:frame3_stop", 64'(tx), 64'd1);
    tick();
    check("flush:idle_busy", 64'(busy), 64'd0);
    capture(25, 1'b0);
    check("flush:idle_tx", pack(0, 25, 1'b0), 64'h1FF_FFFF);
    check("flush:idle_done", pack(0, 25, 1'b1), 64'd0);

    // reset in the middle of a data bit
    cfg_div = 3;
    push(9'h0F0);
    push(9'h033);
    tick();
    repeat (9) tick();
    check("rstmid:pre_tx", 64'(tx), 64'd0);
    check("rstmid:pre_busy", 64'(busy), 64'd1);
    check("rstmid:pre_level", 64'(fifo_level), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid:ready", 64'(s_ready), 64'd0);
    tick();
    check("rstmid:tx", 64'(tx), 64'd1);
    check("rstmid:busy", 64'(busy), 64'd0);
    check("rstmid:level", 64'(fifo_level), 64'd0);
    check("rstmid:done", 64'(tx_done), 64'd0);
    rst_n = 1'b1;
    capture(30, 1'b0);
    check("rstmid:idle_tx", pack(0, 30, 1'b0), 64'h3FFF_FFFF);
    check("rstmid:idle_busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
